// File: rtl/sc_pkg.sv
// Shared types and width helpers for the stochastic stream decoder.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sc_dec_state_t;

  // The ones count can reach exactly 2^width, so it needs one extra bit.
  function automatic int count_w(input int width);
    return width + 1;
  endfunction

  // The bipolar value spans -2^width..+2^width and needs a sign bit on top of that.
  function automatic int bipolar_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Clearable, enabled counter that adds a 1-bit increment. It is used for both
// the sample count (increment tied high) and the ones count (increment = stream bit).
module sc_ones_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH:0]   value
);

  // Clearing takes priority over counting. Each enabled cycle adds 0 or 1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (en) begin
      value <= value + {{WIDTH{1'b0}}, inc};
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Counts the 1s in a window of 2^WIDTH valid stochastic bits. The result is
// presented as a unipolar count and a signed bipolar value, and is handed to
// the host through a valid/ready handshake.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          count,
  output logic signed [WIDTH+1:0] bipolar
);

  localparam int CW = count_w(WIDTH);
  localparam int BW = bipolar_w(WIDTH);
  localparam int N  = 1 << WIDTH;
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(N - 1);
  localparam logic [BW-1:0] N_BW        = BW'(N);

  sc_dec_state_t state, next_state;

  logic [CW-1:0] samples;
  logic [CW-1:0] ones;
  logic [CW-1:0] ones_next;
  logic          clear;
  logic          sample_en;
  logic          last_bit;

  // Computes 2*c - N with modular BW-bit arithmetic. The intermediate 2N
  // wraps to the sign bit, but the subtraction brings the result back into
  // the -N..+N range, which always fits. No saturation is needed.
  function automatic logic signed [BW-1:0] to_bipolar(input logic [CW-1:0] c);
    logic [BW-1:0] twice;
    twice = {c, 1'b0};
    return $signed(twice - N_BW);
  endfunction

  // A new window begins from IDLE on start, or from HOLD when the result is
  // accepted in the same cycle as start (back-to-back windows).
  assign clear     = ((state == IDLE) && start) ||
                     ((state == HOLD) && out_ready && start);
  assign sample_en = (state == ACCUM) && bit_valid;
  assign last_bit  = sample_en && (samples == LAST_SAMPLE);
  assign ones_next = ones + {{WIDTH{1'b0}}, bit_in};

  sc_ones_counter #(.WIDTH(WIDTH)) u_samples (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .en    (sample_en),
    .inc   (1'b1),
    .value (samples)
  );

  sc_ones_counter #(.WIDTH(WIDTH)) u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .en    (sample_en),
    .inc   (bit_in),
    .value (ones)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start is only honoured in IDLE, or in HOLD together with out_ready.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (last_bit) next_state = HOLD;
      HOLD:    if (out_ready) next_state = start ? ACCUM : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // --- result stage: capture the final ones value on the edge that takes the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      bipolar <= '0;
    end else if (last_bit) begin
      count   <= ones_next;
      bipolar <= to_bipolar(ones_next);
    end
  end

  assign busy      = (state == ACCUM);
  assign out_valid = (state == HOLD);

endmodule
